// File: rtl/io_rx_fifo.sv
// io_rx_fifo
// Byte-wide receive FIFO sitting between the UART receiver and the memory
// read path. The read controller maps io_fifo_empty to 0x80000020 and
// io_fifo_dout to 0x80000024; a load from 0x80000024 pops the head entry.
// Writes attempted while full are dropped and recorded in a sticky flag.
//
// Optional feature macro: IO_RX_FIFO_DROP_CNT_EN
//   defined   - drop_count is a saturating 8-bit count of dropped writes
//   undefined - no counter register, drop_count is tied to 0
//
// Parameters:
//   DEPTH_LOG2    log2 of the entry count (1..8)
//   WIDTH         entry width in bits
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr_valid      producer presents wr_data this cycle
//   wr_data       entry to enqueue
//   wr_ready      high when not full
//   ld_valid      core has a valid load in the memory stage
//   ld_addr       effective address of that load
//   io_fifo_empty high when occupancy is zero
//   io_fifo_dout  head entry, 0 when empty (first-word-fall-through)
//   io_fifo_count current occupancy
//   overflow      sticky: a write was attempted while full
//   overflow_clr  clears overflow (and drop_count when built)
//   drop_count    saturating count of dropped writes
module io_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_addr,
  output logic                  io_fifo_empty,
  output logic [WIDTH-1:0]      io_fifo_dout,
  output logic [DEPTH_LOG2:0]   io_fifo_count,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [7:0]            drop_count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0]         POP_ADDR   = 32'h8000_0024;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status flags decode from the registered count only, so there is no
  // combinational path from any input to wr_ready/empty/count.
  assign wr_ready      = (count != FULL_COUNT);
  assign io_fifo_empty = (count == '0);
  assign io_fifo_count = count;
  assign io_fifo_dout  = io_fifo_empty ? '0 : mem[rptr];

  // A pop needs the exact data address; the status address never pops.
  // Pop is gated by empty, so a load racing the first push returns 0.
  assign push = wr_valid && wr_ready;
  assign pop  = ld_valid && (ld_addr == POP_ADDR) && !io_fifo_empty;
  assign drop = wr_valid && !wr_ready;

  // Storage is deliberately left unreset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef IO_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Clearing restarts the count, counting a drop in the same cycle as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else if (overflow_clr) begin
      drop_cnt_q <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule
